// File: rtl/serial_frame_feeder_if.sv
// Bus bundle for serial_frame_feeder: parallel load handshake in, serial bit stream out.
// Handshake: a word transfers on a rising clock edge where load && ready; load while
// ready==0 is dropped (no queueing), and ready depends on feeder state only, never on load.
interface serial_frame_feeder_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             x_out;
  logic             bit_valid;
  logic             word_done;
  logic [CNT_W-1:0] words_sent;
  logic [1:0]       state_dbg;  // 0 IDLE, 1 SHIFT, 2 GAP, 3 PAR

  modport master (
    output data_in, load,
    input  ready, x_out, bit_valid, word_done, words_sent, state_dbg
  );

  modport slave (
    input  data_in, load,
    output ready, x_out, bit_valid, word_done, words_sent, state_dbg
  );
endinterface

// File: rtl/serial_frame_feeder.sv
// Serializes parallel words onto x_out, one bit per clock, with idle-bit gaps between frames.
// Optional feature: define PARITY_EN to append one even-parity bit after the data bits.
module serial_frame_feeder #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_BIT   = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_frame_feeder_if.slave bus
);

  localparam int BIT_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam bit HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] PREV_BIT = BIT_CNT_W'(WIDTH - 2);
  localparam logic [GAP_W-1:0]     LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef PARITY_EN
    S_PAR   = 2'd3,
`endif
    S_GAP   = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     shreg, shreg_nx;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nx;
  logic                 x_q, x_nx;
  logic                 bv_q, bv_nx;
  logic                 wd_q, wd_nx;
  logic [CNT_W-1:0]     words_q;
`ifdef PARITY_EN
  logic                 par_q, par_nx;
`endif

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    x_nx       = IDLE_BIT;
    bv_nx      = 1'b0;
    wd_nx      = 1'b0;
`ifdef PARITY_EN
    par_nx     = par_q;
`endif
    case (state)
      S_IDLE: begin
        if (bus.load) begin
          state_nx   = S_SHIFT;
          bit_cnt_nx = '0;
          bv_nx      = 1'b1;
`ifdef PARITY_EN
          par_nx     = ^bus.data_in;
`endif
          if (MSB_FIRST) begin
            x_nx     = bus.data_in[WIDTH-1];
            shreg_nx = {bus.data_in[WIDTH-2:0], 1'b0};
          end else begin
            x_nx     = bus.data_in[0];
            shreg_nx = {1'b0, bus.data_in[WIDTH-1:1]};
          end
        end
      end
      S_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
          state_nx = S_PAR;
          x_nx     = par_q;
          bv_nx    = 1'b1;
          wd_nx    = 1'b1;
`else
          state_nx   = HAS_GAP ? S_GAP : S_IDLE;
          gap_cnt_nx = '0;
`endif
        end else begin
          bit_cnt_nx = bit_cnt + 1'b1;
          bv_nx      = 1'b1;
`ifndef PARITY_EN
          // Without parity the last data bit closes the frame.
          wd_nx      = (bit_cnt == PREV_BIT);
`endif
          if (MSB_FIRST) begin
            x_nx     = shreg[WIDTH-1];
            shreg_nx = {shreg[WIDTH-2:0], 1'b0};
          end else begin
            x_nx     = shreg[0];
            shreg_nx = {1'b0, shreg[WIDTH-1:1]};
          end
        end
      end
`ifdef PARITY_EN
      S_PAR: begin
        state_nx   = HAS_GAP ? S_GAP : S_IDLE;
        gap_cnt_nx = '0;
      end
`endif
      S_GAP: begin
        if (gap_cnt == LAST_GAP) state_nx = S_IDLE;
        else                     gap_cnt_nx = gap_cnt + 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      x_q     <= IDLE_BIT;
      bv_q    <= 1'b0;
      wd_q    <= 1'b0;
      words_q <= '0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      x_q     <= x_nx;
      bv_q    <= bv_nx;
      wd_q    <= wd_nx;
      // Count lands on the edge that ends the final frame bit; wraps silently.
      if (wd_q) words_q <= words_q + 1'b1;
`ifdef PARITY_EN
      par_q   <= par_nx;
`endif
    end
  end

  assign bus.ready      = (state == S_IDLE);
  assign bus.x_out      = x_q;
  assign bus.bit_valid  = bv_q;
  assign bus.word_done  = wd_q;
  assign bus.words_sent = words_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_serial_frame_feeder.sv
// Directed bench for serial_frame_feeder: two instances (MSB-first with gap, LSB-first
// with no gap and a 2-bit counter), a vector table plus hand-written reset sequences.
module tb_serial_frame_feeder;

`ifdef PARITY_EN
  localparam int PAR_LEN = 1;
`else
  localparam int PAR_LEN = 0;
`endif
  localparam int FL = 8 + PAR_LEN;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_a, rst_b;
  always #5 clock = ~clock;

  serial_frame_feeder_if #(.WIDTH(8), .CNT_W(8)) if_a ();
  serial_frame_feeder_if #(.WIDTH(8), .CNT_W(2)) if_b ();

  serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_BIT(1'b0), .CNT_W(8))
    dut_a (.clock(clock), .reset(rst_a), .bus(if_a));
  serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_BIT(1'b0), .CNT_W(2))
    dut_b (.clock(clock), .reset(rst_b), .bus(if_b));

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [0:0] exp_q[$];
  logic [7:0] exp_cnt_a = '0;
  logic [1:0] exp_cnt_b = '0;

  typedef struct {
    int         sel;       // 0: dut_a, 1: dut_b
    logic [7:0] data;
    logic [7:0] seq;       // expected serial order, seq[7] first
    logic       par;       // expected even-parity bit
    int         pulse_at;  // bit index at which a stray load is pulsed, -1 none
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic ld, input logic [7:0] d);
    if (sel == 0) begin if_a.load = ld; if_a.data_in = d; end
    else          begin if_b.load = ld; if_b.data_in = d; end
  endtask

  task automatic sample(input int sel, output logic x, output logic bv, output logic wd,
                        output logic rdy, output logic [7:0] ws);
    if (sel == 0) begin
      x = if_a.x_out; bv = if_a.bit_valid; wd = if_a.word_done; rdy = if_a.ready;
      ws = if_a.words_sent;
    end else begin
      x = if_b.x_out; bv = if_b.bit_valid; wd = if_b.word_done; rdy = if_b.ready;
      ws = {6'b0, if_b.words_sent};
    end
  endtask

  task automatic run_frame(input int sel, input logic [7:0] d, input logic [7:0] seq,
                           input logic par, input int pulse_at, input string tag);
    logic x, bv, wd, rdy, e;
    logic [7:0] ws;
    int gap    = (sel == 0) ? 2 : 0;
    int waited = 0;
    sample(sel, x, bv, wd, rdy, ws);
    while (!rdy && waited < 50) begin
      @(posedge clock); #1;
      sample(sel, x, bv, wd, rdy, ws);
      waited++;
    end
    check({tag, " ready_before_load"}, rdy, 1);
    for (int i = 7; i >= 0; i--) exp_q.push_back(seq[i]);
    if (PAR_LEN == 1) exp_q.push_back(par);

    @(negedge clock); drive(sel, 1'b1, d);
    @(posedge clock); #1; drive(sel, 1'b0, 8'h00);
    for (int i = 0; i < FL; i++) begin
      if (i > 0) begin @(posedge clock); #1; end
      sample(sel, x, bv, wd, rdy, ws);
      e = exp_q.pop_front();
      check($sformatf("%s x_out bit%0d", tag, i), x, e);
      check($sformatf("%s bit_valid bit%0d", tag, i), bv, 1);
      check($sformatf("%s word_done bit%0d", tag, i), wd, (i == FL - 1));
      check($sformatf("%s ready_busy bit%0d", tag, i), rdy, 0);
      if (i == pulse_at)          drive(sel, 1'b1, ~d);
      else if (i == pulse_at + 1) drive(sel, 1'b0, 8'h00);
    end
    if (sel == 0) exp_cnt_a++; else exp_cnt_b++;

    for (int g = 0; g < gap; g++) begin
      @(posedge clock); #1;
      sample(sel, x, bv, wd, rdy, ws);
      check($sformatf("%s gap%0d x_out", tag, g), x, 0);
      check($sformatf("%s gap%0d bit_valid", tag, g), bv, 0);
      check($sformatf("%s gap%0d ready", tag, g), rdy, 0);
      check($sformatf("%s gap%0d word_done", tag, g), wd, 0);
    end
    @(posedge clock); #1;
    sample(sel, x, bv, wd, rdy, ws);
    check({tag, " idle ready"}, rdy, 1);
    check({tag, " idle bit_valid"}, bv, 0);
    check({tag, " idle x_out"}, x, 0);
    check({tag, " words_sent"}, ws, (sel == 0) ? exp_cnt_a : {6'b0, exp_cnt_b});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic x, bv, wd, rdy;
    logic [7:0] ws;

    vecs[0] = '{0, 8'hB2, 8'b10110010, 1'b0, -1};
    vecs[1] = '{1, 8'hB2, 8'b01001101, 1'b0,  3};
    vecs[2] = '{0, 8'h07, 8'b00000111, 1'b1, -1};
    vecs[3] = '{0, 8'h60, 8'b01100000, 1'b0, -1};
    vecs[4] = '{1, 8'h60, 8'b00000110, 1'b0, -1};
    vecs[5] = '{1, 8'h07, 8'b11100000, 1'b1, -1};
    vecs[6] = '{1, 8'h01, 8'b10000000, 1'b1, -1};
    vecs[7] = '{1, 8'hFF, 8'b11111111, 1'b0, -1};

    // Reset held with load asserted.
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 1'b1, 8'hFF); drive(1, 1'b1, 8'hFF);
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, x, bv, wd, rdy, ws);
      check($sformatf("reset%0d x_out", s), x, 0);
      check($sformatf("reset%0d bit_valid", s), bv, 0);
      check($sformatf("reset%0d word_done", s), wd, 0);
      check($sformatf("reset%0d words_sent", s), ws, 0);
    end
    @(negedge clock);
    drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00);
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clock); #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, x, bv, wd, rdy, ws);
      check($sformatf("post_reset%0d ready", s), rdy, 1);
      check($sformatf("post_reset%0d bit_valid", s), bv, 0);
    end

    // Vector table; dut_b frames run back to back and walk its 2-bit counter through 1,2,3,0,1.
    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].sel, vecs[v].data, vecs[v].seq, vecs[v].par, vecs[v].pulse_at,
                $sformatf("vec%0d", v));

    // Reset asserted while data bit 4 is on the line.
    @(negedge clock); drive(0, 1'b1, 8'hB2);
    @(posedge clock); #1; drive(0, 1'b0, 8'h00);
    repeat (4) begin @(posedge clock); #1; end
    check("midreset bit4 valid", if_a.bit_valid, 1);
    #2 rst_a = 1'b0;
    #1;
    sample(0, x, bv, wd, rdy, ws);
    check("midreset x_out", x, 0);
    check("midreset bit_valid", bv, 0);
    check("midreset word_done", wd, 0);
    check("midreset ready", rdy, 1);
    check("midreset words_sent", ws, 0);
    exp_cnt_a = '0;
    @(negedge clock); rst_a = 1'b1;
    @(posedge clock); #1;
    check("after_midreset word_done", if_a.word_done, 0);
    run_frame(0, 8'hFF, 8'b11111111, 1'b0, -1, "ff_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
